// File: rtl/ttt_turn_ctrl.sv
// ttt_turn_ctrl: sequences one tic-tac-toe game between a human player and a
// combinational strategy datapath.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               begin a new game (honoured in IDLE or OVER only)
//   move_valid, move_in human move request, one-hot square (bit0 top-left)
//   move_ready          high while waiting for a human move
//   move_err            one-cycle pulse for a rejected human move
//   strat_ain/strat_bin computer / human boards driven to the strategy block
//   strat_move          strategy block's chosen square (one-hot expected)
//   board_a, board_b    human / computer squares
//   game_over, result   game finished; 00 none, 01 human, 10 computer, 11 draw
//   win_line            mask of the completed line, 0 if none or draw
//
// Optional macro TTT_TIMEOUT_EN: forfeit the human after TIMEOUT_CYCLES
// cycles in WAIT_H without a legal move.
module ttt_turn_ctrl #(
   parameter bit          HUMAN_FIRST    = 1'b1,
   parameter int unsigned STRAT_WAIT     = 1,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       move_valid,
   input  logic [8:0] move_in,
   output logic       move_ready,
   output logic       move_err,
   output logic [8:0] strat_ain,
   output logic [8:0] strat_bin,
   input  logic [8:0] strat_move,
   output logic [8:0] board_a,
   output logic [8:0] board_b,
   output logic       game_over,
   output logic [1:0] result,
   output logic [8:0] win_line
);

   localparam int unsigned SQ_W  = 9;
   localparam int unsigned CNT_W = $clog2(STRAT_WAIT + 1);

   localparam logic [1:0] RES_NONE  = 2'b00;
   localparam logic [1:0] RES_HUMAN = 2'b01;
   localparam logic [1:0] RES_CPU   = 2'b10;
   localparam logic [1:0] RES_DRAW  = 2'b11;

   localparam logic [SQ_W-1:0] FULL = 9'h1FF;
   localparam logic [SQ_W-1:0] LINES [8] = '{9'h007, 9'h038, 9'h1C0, 9'h049,
                                             9'h092, 9'h124, 9'h111, 9'h054};

   // Elaboration-time parameter sanity checks
   if (STRAT_WAIT < 1) begin : g_chk_wait
      $error("STRAT_WAIT must be >= 1");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
      $error("TIMEOUT_CYCLES must be >= 1");
   end

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_H   = 3'd1,
      S_CHECK_H  = 3'd2,
      S_CPU_WAIT = 3'd3,
      S_CHECK_C  = 3'd4,
      S_OVER     = 3'd5
   } state_t;

   state_t state_q, state_d;

   logic [SQ_W-1:0]  board_a_q, board_a_d;
   logic [SQ_W-1:0]  board_b_q, board_b_d;
   logic [SQ_W-1:0]  win_line_q, win_line_d;
   logic [1:0]       result_q, result_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             move_ready_q, move_ready_d;
   logic             move_err_q, move_err_d;
   logic             game_over_q, game_over_d;

   logic [SQ_W-1:0]  occ;
   logic [SQ_W-1:0]  win_a, win_b;
   logic             human_legal, strat_legal, board_full, cnt_last;
   logic             timeout_hit;

   // Legal = exactly one bit set and that square still empty
   function automatic logic is_legal(input logic [SQ_W-1:0] mv,
                                     input logic [SQ_W-1:0] taken);
      return (mv != '0) && ((mv & (mv - SQ_W'(1))) == '0) && ((mv & taken) == '0);
   endfunction

   // First completed line in list order; later list entries are overridden
   function automatic logic [SQ_W-1:0] first_line(input logic [SQ_W-1:0] b);
      logic [SQ_W-1:0] hit;
      hit = '0;
      for (int i = 7; i >= 0; i--) begin
         if ((b & LINES[i]) == LINES[i]) hit = LINES[i];
      end
      return hit;
   endfunction

   // Isolate the lowest clear bit of the occupancy map
   function automatic logic [SQ_W-1:0] lowest_empty(input logic [SQ_W-1:0] taken);
      logic [SQ_W-1:0] e;
      e = ~taken;
      return e & (~e + SQ_W'(1));
   endfunction

   assign occ         = board_a_q | board_b_q;
   assign human_legal = move_valid && is_legal(move_in, occ);
   assign strat_legal = is_legal(strat_move, occ);
   assign win_a       = first_line(board_a_q);
   assign win_b       = first_line(board_b_q);
   assign board_full  = (occ == FULL);
   assign cnt_last    = (cnt_q == CNT_W'(1));

`ifdef TTT_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   assign timeout_hit = (state_q == S_WAIT_H) &&
                        (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   // Counts cycles spent in WAIT_H; zero on every fresh entry
   always_comb begin
      to_cnt_d = '0;
      if (state_q == S_WAIT_H && state_d == S_WAIT_H) to_cnt_d = to_cnt_q + TO_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) to_cnt_q <= '0;
      else       to_cnt_q <= to_cnt_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_OVER: begin
            if (start) state_d = HUMAN_FIRST ? S_WAIT_H : S_CPU_WAIT;
         end
         S_WAIT_H: begin
            if (human_legal)      state_d = S_CHECK_H;
            else if (timeout_hit) state_d = S_OVER;
         end
         S_CHECK_H: begin
            if (win_a != '0 || board_full) state_d = S_OVER;
            else                           state_d = S_CPU_WAIT;
         end
         S_CPU_WAIT: begin
            if (cnt_last) state_d = S_CHECK_C;
         end
         S_CHECK_C: begin
            if (win_b != '0 || board_full) state_d = S_OVER;
            else                           state_d = S_WAIT_H;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      board_a_d  = board_a_q;
      board_b_d  = board_b_q;
      result_d   = result_q;
      win_line_d = win_line_q;
      cnt_d      = cnt_q;
      move_err_d = 1'b0;
      case (state_q)
         S_IDLE, S_OVER: begin
            if (start) begin
               board_a_d  = '0;
               board_b_d  = '0;
               result_d   = RES_NONE;
               win_line_d = '0;
               cnt_d      = CNT_W'(STRAT_WAIT);
            end
         end
         S_WAIT_H: begin
            if (human_legal) begin
               board_a_d = board_a_q | move_in;
            end else begin
               if (move_valid) move_err_d = 1'b1;
               if (timeout_hit) begin
                  result_d   = RES_CPU;
                  win_line_d = '0;
               end
            end
         end
         S_CHECK_H: begin
            if (win_a != '0) begin
               result_d   = RES_HUMAN;
               win_line_d = win_a;
            end else if (board_full) begin
               result_d   = RES_DRAW;
               win_line_d = '0;
            end else begin
               cnt_d = CNT_W'(STRAT_WAIT);
            end
         end
         S_CPU_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            // Strategy inputs have been stable for STRAT_WAIT cycles here
            if (cnt_last) begin
               board_b_d = board_b_q | (strat_legal ? strat_move : lowest_empty(occ));
            end
         end
         S_CHECK_C: begin
            if (win_b != '0) begin
               result_d   = RES_CPU;
               win_line_d = win_b;
            end else if (board_full) begin
               result_d   = RES_DRAW;
               win_line_d = '0;
            end
         end
         default: ;
      endcase
      move_ready_d = (state_d == S_WAIT_H);
      game_over_d  = (state_d == S_OVER);
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         board_a_q    <= '0;
         board_b_q    <= '0;
         result_q     <= RES_NONE;
         win_line_q   <= '0;
         cnt_q        <= '0;
         move_ready_q <= 1'b0;
         move_err_q   <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         board_a_q    <= board_a_d;
         board_b_q    <= board_b_d;
         result_q     <= result_d;
         win_line_q   <= win_line_d;
         cnt_q        <= cnt_d;
         move_ready_q <= move_ready_d;
         move_err_q   <= move_err_d;
         game_over_q  <= game_over_d;
      end
   end

   assign board_a    = board_a_q;
   assign board_b    = board_b_q;
   assign strat_ain  = board_b_q;
   assign strat_bin  = board_a_q;
   assign result     = result_q;
   assign win_line   = win_line_q;
   assign move_ready = move_ready_q;
   assign move_err   = move_err_q;
   assign game_over  = game_over_q;

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// Scoreboard bench for ttt_turn_ctrl: a cell-level game model predicts every
// observable event (ready, error pulse, game over) with its cycle and boards.
module tb_ttt_turn_ctrl;

   localparam int unsigned SW = 2;

   logic       clk = 1'b0;
   logic       reset, start, move_valid;
   logic [8:0] move_in, strat_move;
   logic       move_ready, move_err, game_over;
   logic [8:0] strat_ain, strat_bin, board_a, board_b, win_line;
   logic [1:0] result;

   ttt_turn_ctrl #(.HUMAN_FIRST(1'b1), .STRAT_WAIT(SW), .TIMEOUT_CYCLES(1000)) dut (
      .clk(clk), .reset(reset), .start(start), .move_valid(move_valid),
      .move_in(move_in), .move_ready(move_ready), .move_err(move_err),
      .strat_ain(strat_ain), .strat_bin(strat_bin), .strat_move(strat_move),
      .board_a(board_a), .board_b(board_b), .game_over(game_over),
      .result(result), .win_line(win_line));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum int {K_READY = 0, K_ERR = 1, K_OVER = 2} kind_t;
   typedef struct {
      kind_t      kind;
      logic [8:0] ba;
      logic [8:0] bb;
      logic [1:0] res;
      logic [8:0] wl;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   owner[9];        // 0 empty, 1 human, 2 computer
   bit   over_m;
   int   ln[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   task automatic cmp(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [8:0] mask_of(input int who);
      logic [8:0] m = '0;
      for (int i = 0; i < 9; i++) if (owner[i] == who) m = m | (9'd1 << i);
      return m;
   endfunction

   function automatic int find_win(input int who);
      for (int l = 0; l < 8; l++)
         if (owner[ln[l][0]] == who && owner[ln[l][1]] == who && owner[ln[l][2]] == who)
            return l;
      return -1;
   endfunction

   function automatic logic [8:0] line_mask(input int l);
      return (9'd1 << ln[l][0]) | (9'd1 << ln[l][1]) | (9'd1 << ln[l][2]);
   endfunction

   function automatic bit is_full();
      for (int i = 0; i < 9; i++) if (owner[i] == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int first_free();
      for (int i = 0; i < 9; i++) if (owner[i] == 0) return i;
      return -1;
   endfunction

   // Square index if the pattern selects exactly one empty square, else -1
   function automatic int legal_idx(input logic [8:0] p);
      int idx = -1;
      if ($countones(p) != 1) return -1;
      for (int i = 0; i < 9; i++) if (p[i]) idx = i;
      if (owner[idx] != 0) return -1;
      return idx;
   endfunction

   task automatic push(input kind_t k, input logic [1:0] res, input logic [8:0] wl, input int c);
      exp_t e;
      e.kind = k; e.ba = mask_of(1); e.bb = mask_of(2);
      e.res = res; e.wl = wl; e.cyc = c;
      sb.push_back(e);
   endtask

   // Monitor: every observable DUT event consumes one scoreboard entry
   task automatic check_evt(input kind_t k);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL unexpected_event: kind %0d with nothing expected (cycle %0d)", int'(k), cyc);
         return;
      end
      e = sb.pop_front();
      cmp("evt_kind", int'(k), int'(e.kind));
      cmp("evt_cycle", cyc, e.cyc);
      cmp("board_a", int'(board_a), int'(e.ba));
      cmp("board_b", int'(board_b), int'(e.bb));
      cmp("strat_bin", int'(strat_bin), int'(e.ba));
      cmp("strat_ain", int'(strat_ain), int'(e.bb));
      if (k == K_OVER) begin
         cmp("result", int'(result), int'(e.res));
         cmp("win_line", int'(win_line), int'(e.wl));
      end
   endtask

   bit prev_ready = 1'b0, prev_over = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         if (move_err)                check_evt(K_ERR);
         if (move_ready && !prev_ready) check_evt(K_READY);
         if (game_over && !prev_over)   check_evt(K_OVER);
      end
      prev_ready = move_ready;
      prev_over  = game_over;
   end

   // All drive tasks start and end #1 after a rising edge
   task automatic wait_drain();
      for (int i = 0; i < 100; i++) begin
         if (sb.size() == 0) return;
         @(posedge clk); #1;
      end
      cmp("drain_timeout", sb.size(), 0);
      sb.delete();
   endtask

   task automatic wait_ready(output bit ok);
      for (int i = 0; i < 100; i++) begin
         if (move_ready) begin ok = 1'b1; return; end
         @(posedge clk); #1;
      end
      ok = 1'b0;
      cmp("ready_timeout", int'(move_ready), 1);
   endtask

   task automatic do_start();
      for (int i = 0; i < 9; i++) owner[i] = 0;
      over_m = 1'b0;
      push(K_READY, 2'b00, 9'h000, cyc + 1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_drain();
   endtask

   task automatic human_move(input logic [8:0] mv, input logic [8:0] st);
      bit ok;
      int acc, idx, c, w;
      wait_ready(ok);
      if (!ok) begin over_m = 1'b1; return; end
      acc = cyc + 1;
      idx = legal_idx(mv);
      if (idx < 0) begin
         push(K_ERR, 2'b00, 9'h000, acc);
         move_valid = 1'b1; move_in = mv;
         @(posedge clk); #1;
         move_valid = 1'b0;
         wait_drain();
         return;
      end
      owner[idx] = 1;
      w = find_win(1);
      if (w >= 0) begin
         push(K_OVER, 2'b01, line_mask(w), acc + 1); over_m = 1'b1;
      end else if (is_full()) begin
         push(K_OVER, 2'b11, 9'h000, acc + 1); over_m = 1'b1;
      end else begin
         c = legal_idx(st);
         if (c < 0) c = first_free();
         owner[c] = 2;
         w = find_win(2);
         if (w >= 0) begin
            push(K_OVER, 2'b10, line_mask(w), acc + SW + 2); over_m = 1'b1;
         end else if (is_full()) begin
            push(K_OVER, 2'b11, 9'h000, acc + SW + 2); over_m = 1'b1;
         end else begin
            push(K_READY, 2'b00, 9'h000, acc + SW + 2);
         end
      end
      strat_move = st;
      move_valid = 1'b1; move_in = mv;
      @(posedge clk); #1;
      // Junk requests while it is not the human's turn must be ignored
      for (int k = 0; k < int'(SW) + 2; k++) begin
         move_in = 9'($urandom);
         @(posedge clk); #1;
      end
      move_valid = 1'b0; move_in = '0;
      wait_drain();
   endtask

   function automatic logic [8:0] rand_pattern(input bit want_legal);
      int i, r;
      if (want_legal) begin
         do i = $urandom_range(0, 8); while (owner[i] != 0);
         return 9'd1 << i;
      end
      r = $urandom_range(0, 2);
      if (r == 0 && first_free() != 0) begin
         do i = $urandom_range(0, 8); while (owner[i] == 0);
         return 9'd1 << i;
      end
      if (r == 1) return 9'h000;
      return 9'h003 << $urandom_range(0, 7);
   endfunction

   function automatic logic [8:0] rand_strat();
      int r = $urandom_range(0, 3);
      if (r <= 1) return rand_pattern(1'b1);
      if (r == 2) return rand_pattern(1'b0);
      return 9'($urandom);
   endfunction

   initial begin
      reset = 1'b1; start = 1'b0; move_valid = 1'b0;
      move_in = '0; strat_move = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      cmp("rst_move_ready", int'(move_ready), 0);
      cmp("rst_game_over", int'(game_over), 0);
      cmp("rst_board_a", int'(board_a), 0);
      cmp("rst_board_b", int'(board_b), 0);
      cmp("rst_result", int'(result), 0);
      cmp("rst_win_line", int'(win_line), 0);

      // Move request in IDLE is ignored
      move_valid = 1'b1; move_in = 9'h010;
      repeat (2) begin @(posedge clk); #1; end
      move_valid = 1'b0;
      cmp("idle_move_err", int'(move_err), 0);
      cmp("idle_board_a", int'(board_a), 0);

      // Game 1: rejects, strategy fallback, human column win
      do_start();
      human_move(9'h010, 9'h001);
      human_move(9'h010, 9'h000);
      human_move(9'h003, 9'h000);
      human_move(9'h000, 9'h000);
      human_move(9'h002, 9'h001);
      human_move(9'h100, 9'h000);
      human_move(9'h080, 9'h000);

      // Game 2: human top row
      do_start();
      human_move(9'h001, 9'h010);
      human_move(9'h002, 9'h020);
      human_move(9'h004, 9'h000);

      // Game 3: draw
      do_start();
      human_move(9'h001, 9'h010);
      human_move(9'h004, 9'h002);
      human_move(9'h080, 9'h040);
      human_move(9'h008, 9'h020);
      human_move(9'h100, 9'h000);

      // Game 4: computer anti-diagonal
      do_start();
      human_move(9'h001, 9'h010);
      human_move(9'h002, 9'h004);
      human_move(9'h100, 9'h040);

      // Random games
      for (int g = 0; g < 25; g++) begin
         do_start();
         for (int t = 0; t < 40 && !over_m; t++) begin
            if ($urandom_range(0, 5) == 0) begin
               start = 1'b1;          // ignored while waiting for the human
               @(posedge clk); #1;
               start = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) human_move(rand_pattern(1'b0), rand_strat());
            else                           human_move(rand_pattern(1'b1), rand_strat());
         end
      end

      // Reset in the middle of the computer's turn
      do_start();
      strat_move = 9'h001; move_valid = 1'b1; move_in = 9'h010;
      @(posedge clk); #1;
      move_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      cmp("midrst_board_a", int'(board_a), 0);
      cmp("midrst_board_b", int'(board_b), 0);
      cmp("midrst_move_ready", int'(move_ready), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (SW + 3) begin @(posedge clk); #1; end
      cmp("postrst_board_b", int'(board_b), 0);
      cmp("postrst_move_ready", int'(move_ready), 0);
      cmp("postrst_game_over", int'(game_over), 0);

      cmp("sb_leftover", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
